hdd_block_arbiter: RTL and testbench

- N-unit successor to the two-unit HDD request/ack sequencer in the sim top.
- Captures read/write block requests from the iigs core HDD port, queues one read and one write per unit, and arbitrates round-robin among units.
- Drives per-unit sd_rd/sd_wr/sd_lba toward the block-device host and holds cpu_wait until the queue drains.
- Adds mount tracking, write-protect rejection, unmount abort and ack timeout.

---
 rtl/hdd_block_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_hdd_block_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdd_block_arbiter.sv
// N-unit HDD block request arbiter: queues one read and one write per unit, serves
// units round-robin toward the block-device host and stalls the CPU until drained.
module hdd_block_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int UNIT_W    = 2,
    parameter int SECTOR_W  = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic [UNIT_W-1:0]       req_unit,
    input  logic [SECTOR_W-1:0]     req_sector,
    input  logic [NUM_UNITS-1:0]    img_mounted,
    input  logic                    img_size_nz,
    input  logic                    img_readonly,
    input  logic [NUM_UNITS-1:0]    sd_ack,
    output logic [NUM_UNITS-1:0]    sd_rd,
    output logic [NUM_UNITS-1:0]    sd_wr,
    output logic [32*NUM_UNITS-1:0] sd_lba,
    output logic [UNIT_W-1:0]       active_unit,
    output logic                    active_ack,
    output logic                    cpu_wait,
    output logic [NUM_UNITS-1:0]    hdd_mounted,
    output logic [NUM_UNITS-1:0]    hdd_protect,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    // Timeout fires on the edge that brings the counter to 2^TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                 state_r, state_s;
    logic [NUM_UNITS-1:0]   pend_rd_r, pend_wr_r, pend_rd_s, pend_wr_s;
    logic [SECTOR_W-1:0]    sector_rd_r [NUM_UNITS];
    logic [SECTOR_W-1:0]    sector_wr_r [NUM_UNITS];
    logic [NUM_UNITS-1:0]   mounted_r, protect_r;
    logic [UNIT_W-1:0]      rr_ptr_r, active_unit_r;
    logic                   active_wr_r;
    logic [NUM_UNITS-1:0]   sd_rd_r, sd_wr_r;
    logic [31:0]            sd_lba_r [NUM_UNITS];
    logic                   ack_prev_r;
    logic [TIMEOUT_W-1:0]   tmo_cnt_r;
    logic                   cpu_wait_r, done_r, error_r;
    logic [1:0]             err_code_r;

    logic [NUM_UNITS-1:0]   req_sel_s, active_sel_s, unmount_s, eligible_s, pick_sel_s;
    logic                   mounted_hit_s, protect_hit_s, rd_pend_hit_s, wr_pend_hit_s;
    logic                   rd_reject_s, wr_reject_s, rd_overrun_s, wr_overrun_s;
    logic                   cap_rd_s, cap_wr_s;
    logic                   pick_valid_s, pick_wr_s;
    logic [UNIT_W-1:0]      pick_unit_s;
    logic [SECTOR_W-1:0]    pick_sector_s;
    logic                   rise_s, fall_s, active_unmount_s, tmo_hit_s;
    logic                   fsm_issue_s, fsm_drop_s, served_clr_s, done_s, rr_upd_s;
    logic                   fsm_err_s;
    logic [1:0]             fsm_code_s;
    logic                   cpu_wait_s, error_s;
    logic [1:0]             err_code_s;

    // One-hot decode of the request target and the unit being served
    always_comb begin
        req_sel_s    = '0;
        active_sel_s = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            req_sel_s[u]    = (int'(req_unit) == u);
            active_sel_s[u] = (int'(active_unit_r) == u);
        end
    end

    assign unmount_s        = img_mounted & {NUM_UNITS{~img_size_nz}};
    assign mounted_hit_s    = |(req_sel_s & mounted_r);
    assign protect_hit_s    = |(req_sel_s & protect_r);
    assign rd_pend_hit_s    = |(req_sel_s & pend_rd_r);
    assign wr_pend_hit_s    = |(req_sel_s & pend_wr_r);
    assign rd_reject_s      = req_read & ~mounted_hit_s;
    assign rd_overrun_s     = req_read & mounted_hit_s & rd_pend_hit_s;
    assign cap_rd_s         = req_read & mounted_hit_s & ~rd_pend_hit_s;
    assign wr_reject_s      = req_write & (~mounted_hit_s | protect_hit_s);
    assign wr_overrun_s     = req_write & mounted_hit_s & ~protect_hit_s & wr_pend_hit_s;
    assign cap_wr_s         = req_write & mounted_hit_s & ~protect_hit_s & ~wr_pend_hit_s;

    assign active_ack       = |(sd_ack & active_sel_s);
    assign rise_s           = active_ack & ~ack_prev_r;
    assign fall_s           = ~active_ack & ack_prev_r;
    assign active_unmount_s = |(unmount_s & active_sel_s);
    assign tmo_hit_s        = (tmo_cnt_r == TMO_LAST);
    // A unit unmounting this cycle is not worth starting a transfer on.
    assign eligible_s       = (pend_rd_r | pend_wr_r) & ~unmount_s;

    // Round-robin pick starting after rr_ptr; write wins over read within a unit
    always_comb begin
        pick_valid_s  = 1'b0;
        pick_unit_s   = '0;
        pick_wr_s     = 1'b0;
        pick_sel_s    = '0;
        pick_sector_s = '0;
        for (int i = 1; i <= NUM_UNITS; i++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (!pick_valid_s && eligible_s[u] && (((int'(rr_ptr_r) + i) % NUM_UNITS) == u)) begin
                    pick_valid_s  = 1'b1;
                    pick_unit_s   = UNIT_W'(u);
                    pick_wr_s     = pend_wr_r[u];
                    pick_sel_s[u] = 1'b1;
                    pick_sector_s = pend_wr_r[u] ? sector_wr_r[u] : sector_rd_r[u];
                end else begin
                    pick_valid_s  = pick_valid_s;
                end
            end
        end
    end

    // Next-state logic and FSM events
    always_comb begin
        state_s      = state_r;
        fsm_issue_s  = 1'b0;
        fsm_drop_s   = 1'b0;
        served_clr_s = 1'b0;
        done_s       = 1'b0;
        rr_upd_s     = 1'b0;
        fsm_err_s    = 1'b0;
        fsm_code_s   = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s     = ST_ISSUE;
                    fsm_issue_s = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_ISSUE, ST_XFER: begin
                if (active_unmount_s) begin
                    state_s    = ST_IDLE;
                    fsm_drop_s = 1'b1;
                    fsm_err_s  = 1'b1;
                    fsm_code_s = 2'd3;
                end else if (tmo_hit_s) begin
                    state_s      = ST_IDLE;
                    fsm_drop_s   = 1'b1;
                    served_clr_s = 1'b1;
                    fsm_err_s    = 1'b1;
                    fsm_code_s   = 2'd2;
                end else if ((state_r == ST_ISSUE) && rise_s) begin
                    state_s    = ST_XFER;
                    fsm_drop_s = 1'b1;
                end else if ((state_r == ST_XFER) && fall_s) begin
                    state_s      = ST_IDLE;
                    served_clr_s = 1'b1;
                    done_s       = 1'b1;
                    rr_upd_s     = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                fsm_drop_s = 1'b1;
            end
        endcase
    end

    // Pending bits: served clear, then capture, then unmount flush
    always_comb begin
        pend_rd_s = pend_rd_r;
        pend_wr_s = pend_wr_r;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (served_clr_s && active_sel_s[u]) begin
                if (active_wr_r) begin
                    pend_wr_s[u] = 1'b0;
                end else begin
                    pend_rd_s[u] = 1'b0;
                end
            end else begin
                pend_rd_s[u] = pend_rd_s[u];
            end
            if (cap_rd_s && req_sel_s[u]) begin
                pend_rd_s[u] = 1'b1;
            end else begin
                pend_rd_s[u] = pend_rd_s[u];
            end
            if (cap_wr_s && req_sel_s[u]) begin
                pend_wr_s[u] = 1'b1;
            end else begin
                pend_wr_s[u] = pend_wr_s[u];
            end
            if (unmount_s[u]) begin
                pend_rd_s[u] = 1'b0;
                pend_wr_s[u] = 1'b0;
            end else begin
                pend_wr_s[u] = pend_wr_s[u];
            end
        end
    end

    // CPU stall and error reporting; capture errors take precedence over FSM errors
    always_comb begin
        cpu_wait_s = cpu_wait_r;
        error_s    = fsm_err_s;
        err_code_s = fsm_code_s;
        if (cap_rd_s || cap_wr_s) begin
            cpu_wait_s = 1'b1;
        end else if ((state_s == ST_IDLE) && (pend_rd_s == '0) && (pend_wr_s == '0)) begin
            cpu_wait_s = 1'b0;
        end else begin
            cpu_wait_s = cpu_wait_r;
        end
        if (rd_reject_s || wr_reject_s) begin
            error_s    = 1'b1;
            err_code_s = 2'd0;
        end else if (rd_overrun_s || wr_overrun_s) begin
            error_s    = 1'b1;
            err_code_s = 2'd1;
        end else begin
            error_s    = fsm_err_s;
        end
    end

    // State register, per-state timeout counter and ack history
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= '0;
            ack_prev_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ack_prev_r <= active_ack;
            if ((state_s != state_r) || (state_r == ST_IDLE)) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end
        end
    end

    // Strobes, LBA registers, active unit and round-robin pointer
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_rd_r       <= '0;
            sd_wr_r       <= '0;
            active_unit_r <= '0;
            active_wr_r   <= 1'b0;
            rr_ptr_r      <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                sd_lba_r[u] <= 32'd0;
            end
        end else begin
            if (fsm_issue_s) begin
                active_unit_r <= pick_unit_s;
                active_wr_r   <= pick_wr_s;
                sd_rd_r       <= pick_wr_s ? '0 : pick_sel_s;
                sd_wr_r       <= pick_wr_s ? pick_sel_s : '0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (pick_sel_s[u]) begin
                        sd_lba_r[u] <= 32'(pick_sector_s);
                    end
                end
            end else if (fsm_drop_s) begin
                sd_rd_r <= '0;
                sd_wr_r <= '0;
            end
            if (rr_upd_s) begin
                rr_ptr_r <= active_unit_r;
            end
        end
    end

    // Request queue, sector latches and mount status
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_rd_r <= '0;
            pend_wr_r <= '0;
            mounted_r <= '0;
            protect_r <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                sector_rd_r[u] <= '0;
                sector_wr_r[u] <= '0;
            end
        end else begin
            pend_rd_r <= pend_rd_s;
            pend_wr_r <= pend_wr_s;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (cap_rd_s && req_sel_s[u]) begin
                    sector_rd_r[u] <= req_sector;
                end
                if (cap_wr_s && req_sel_s[u]) begin
                    sector_wr_r[u] <= req_sector;
                end
                if (img_mounted[u]) begin
                    mounted_r[u] <= img_size_nz;
                    protect_r[u] <= img_readonly;
                end
            end
        end
    end

    // Status pulses and CPU stall register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_wait_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= 2'd0;
        end else begin
            cpu_wait_r <= cpu_wait_s;
            done_r     <= done_s;
            error_r    <= error_s;
            err_code_r <= err_code_s;
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lba
        assign sd_lba[32*g +: 32] = sd_lba_r[g];
    end

    assign sd_rd       = sd_rd_r;
    assign sd_wr       = sd_wr_r;
    assign active_unit = active_unit_r;
    assign cpu_wait    = cpu_wait_r;
    assign hdd_mounted = mounted_r;
    assign hdd_protect = protect_r;
    assign done        = done_r;
    assign error       = error_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_hdd_block_arbiter.sv
// Directed bench for hdd_block_arbiter: capture, round-robin order, rejection,
// write priority, timeout, unmount abort and mid-transfer reset.
module tb_hdd_block_arbiter;

    localparam int NU = 4;
    localparam int UW = 2;
    localparam int SW = 16;
    localparam int TW = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            req_read, req_write;
    logic [UW-1:0]   req_unit;
    logic [SW-1:0]   req_sector;
    logic [NU-1:0]   img_mounted;
    logic            img_size_nz, img_readonly;
    logic [NU-1:0]   sd_ack;
    logic [NU-1:0]   sd_rd, sd_wr;
    logic [32*NU-1:0] sd_lba;
    logic [UW-1:0]   active_unit;
    logic            active_ack, cpu_wait, done, error;
    logic [NU-1:0]   hdd_mounted, hdd_protect;
    logic [1:0]      err_code;

    int n_run  = 0;
    int n_fail = 0;

    hdd_block_arbiter #(
        .NUM_UNITS(NU), .UNIT_W(UW), .SECTOR_W(SW), .TIMEOUT_W(TW)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_unit(req_unit), .req_sector(req_sector),
        .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
        .sd_ack(sd_ack), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .active_unit(active_unit), .active_ack(active_ack), .cpu_wait(cpu_wait),
        .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input int u, input int sec);
        req_read   = rd;
        req_write  = wr;
        req_unit   = UW'(u);
        req_sector = SW'(sec);
        tick();
        req_read   = 1'b0;
        req_write  = 1'b0;
    endtask

    task automatic do_mount(input logic [NU-1:0] m, input bit nz, input bit ro);
        img_mounted  = m;
        img_size_nz  = nz;
        img_readonly = ro;
        tick();
        img_mounted  = '0;
    endtask

    task automatic wait_strobe();
        int k;
        k = 0;
        while (((sd_rd | sd_wr) == '0) && (k < 20)) begin
            tick();
            k++;
        end
    endtask

    // Waits for the next strobe, checks it, then runs a full ack handshake.
    task automatic serve(input string tag, input int u, input bit wr, input logic [31:0] lba);
        wait_strobe();
        chk({tag, "_rd"}, 32'(sd_rd), wr ? 32'd0 : (32'd1 << u));
        chk({tag, "_wr"}, 32'(sd_wr), wr ? (32'd1 << u) : 32'd0);
        chk({tag, "_lba"}, sd_lba[32*u +: 32], lba);
        chk({tag, "_unit"}, 32'(active_unit), 32'(u));
        chk({tag, "_wait"}, 32'(cpu_wait), 32'd1);
        sd_ack    = '0;
        sd_ack[u] = 1'b1;
        tick();
        chk({tag, "_drop"}, 32'(sd_rd | sd_wr), 32'd0);
        sd_ack = '0;
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_unit = '0; req_sector = '0;
        img_mounted = '0; img_size_nz = 1'b0; img_readonly = 1'b0; sd_ack = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_strobes", 32'(sd_rd | sd_wr), 32'd0);
        chk("rst_mounted", 32'(hdd_mounted), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_lba0", sd_lba[31:0], 32'd0);

        // Single read on unit 2
        do_mount(4'b0100, 1'b1, 1'b0);
        chk("t1_mounted", 32'(hdd_mounted), 32'h4);
        do_req(1'b1, 1'b0, 2, 16'h0123);
        chk("t1_wait", 32'(cpu_wait), 32'd1);
        chk("t1_no_strobe", 32'(sd_rd), 32'd0);
        tick();
        chk("t1_rd", 32'(sd_rd), 32'h4);
        chk("t1_lba", sd_lba[95:64], 32'h0000_0123);
        chk("t1_unit", 32'(active_unit), 32'd2);
        sd_ack = 4'b0100;
        tick();
        chk("t1_rd_drop", 32'(sd_rd), 32'd0);
        chk("t1_active_ack", 32'(active_ack), 32'd1);
        chk("t1_no_done", 32'(done), 32'd0);
        sd_ack = '0;
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_wait_clr", 32'(cpu_wait), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Round robin from rr_ptr=0: requests arrive 1,0,3 and are served 1,3,0
        do_reset();
        do_mount(4'b1011, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 1, 16'h0011);
        do_req(1'b1, 1'b0, 0, 16'h0010);
        do_req(1'b1, 1'b0, 3, 16'h0013);
        serve("t2_a", 1, 1'b0, 32'h11);
        serve("t2_b", 3, 1'b0, 32'h13);
        serve("t2_c", 0, 1'b0, 32'h10);
        chk("t2_wait_clr", 32'(cpu_wait), 32'd0);

        // Protected and unmounted rejections
        do_reset();
        do_mount(4'b0010, 1'b1, 1'b1);
        chk("t3_protect", 32'(hdd_protect), 32'h2);
        do_req(1'b0, 1'b1, 1, 16'h0042);
        chk("t3_wp_err", 32'(error), 32'd1);
        chk("t3_wp_code", 32'(err_code), 32'd0);
        tick();
        chk("t3_wp_nostrobe", 32'(sd_wr | sd_rd), 32'd0);
        chk("t3_wp_nowait", 32'(cpu_wait), 32'd0);
        do_req(1'b1, 1'b0, 3, 16'h0007);
        chk("t3_um_err", 32'(error), 32'd1);
        chk("t3_um_code", 32'(err_code), 32'd0);
        tick();
        chk("t3_um_nostrobe", 32'(sd_rd), 32'd0);
        do_req(1'b1, 1'b0, 1, 16'h0042);
        chk("t3_ro_read_ok", 32'(error), 32'd0);
        serve("t3_ro", 1, 1'b0, 32'h42);

        // Write priority within a unit, and overrun keeps the first sector
        do_reset();
        do_mount(4'b0011, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 1, 16'h0077);
        wait_strobe();
        do_req(1'b1, 1'b0, 0, 16'h0005);
        do_req(1'b0, 1'b1, 0, 16'h0009);
        chk("t4_wr_ok", 32'(error), 32'd0);
        do_req(1'b1, 1'b0, 0, 16'h0006);
        chk("t4_ovr_err", 32'(error), 32'd1);
        chk("t4_ovr_code", 32'(err_code), 32'd1);
        serve("t4_u1", 1, 1'b0, 32'h77);
        serve("t4_wr", 0, 1'b1, 32'h9);
        serve("t4_rd", 0, 1'b0, 32'h5);
        chk("t4_wait_clr", 32'(cpu_wait), 32'd0);

        // Ack never returns: timeout after 15 cycles in ISSUE
        do_reset();
        do_mount(4'b0100, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 2, 16'h0055);
        wait_strobe();
        chk("t5_rd", 32'(sd_rd), 32'h4);
        n = 0;
        while (!error && (n < 40)) begin
            tick();
            n++;
        end
        chk("t5_cycles", 32'(n), 32'd15);
        chk("t5_code", 32'(err_code), 32'd2);
        chk("t5_rd_drop", 32'(sd_rd), 32'd0);
        chk("t5_wait_clr", 32'(cpu_wait), 32'd0);

        // Unmount of the active unit during XFER
        do_reset();
        do_mount(4'b1000, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 3, 16'h0033);
        wait_strobe();
        sd_ack = 4'b1000;
        tick();
        chk("t6_xfer_drop", 32'(sd_rd), 32'd0);
        do_mount(4'b1000, 1'b0, 1'b0);
        chk("t6_abort_err", 32'(error), 32'd1);
        chk("t6_abort_code", 32'(err_code), 32'd3);
        chk("t6_unmounted", 32'(hdd_mounted), 32'd0);
        chk("t6_strobes", 32'(sd_rd | sd_wr), 32'd0);
        chk("t6_wait_clr", 32'(cpu_wait), 32'd0);
        sd_ack = '0;
        tick();
        chk("t6_no_done", 32'(done), 32'd0);

        // Reset asserted mid-ISSUE
        do_mount(4'b1000, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 3, 16'h0034);
        wait_strobe();
        chk("t6_issue_rd", 32'(sd_rd), 32'h8);
        do_reset();
        chk("t6_rst_rd", 32'(sd_rd), 32'd0);
        chk("t6_rst_wait", 32'(cpu_wait), 32'd0);
        chk("t6_rst_mounted", 32'(hdd_mounted), 32'd0);
        chk("t6_rst_unit", 32'(active_unit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
